// File: rtl/note_slot_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : note_slot_scheduler
// Brief    : Beat-scheduled chart fetch, lane-to-slot allocation and per-frame
//            movement of falling notes. Define LOOP_CHART_EN to repeat the chart.
// Revision : 1.0 - initial release
// ============================================================================
module note_slot_scheduler #(
    parameter int NUM_SLOTS       = 8,
    parameter int CHART_AW        = 5,
    parameter int SCREEN_H        = 480,
    parameter int SPEED           = 1,
    parameter int FRAMES_PER_BEAT = 120
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    frame_tick,
    output logic [CHART_AW-1:0]     chart_addr,
    input  logic [3:0]              chart_data,
    output logic [NUM_SLOTS-1:0]    slot_valid,
    output logic [2*NUM_SLOTS-1:0]  slot_lane,
    output logic [10*NUM_SLOTS-1:0] slot_y,
    output logic                    overflow,
    output logic                    chart_done
);

    localparam int c_CNT_W = (FRAMES_PER_BEAT > 1) ? $clog2(FRAMES_PER_BEAT) : 1;
    localparam logic [c_CNT_W-1:0] c_BEAT_LAST = c_CNT_W'(FRAMES_PER_BEAT - 1);
    localparam logic [10:0]        c_SPEED     = 11'(SPEED);
    localparam logic [10:0]        c_SCREEN_H  = 11'(SCREEN_H);
`ifdef LOOP_CHART_EN
    localparam logic c_LOOP = 1'b1;
`else
    localparam logic c_LOOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ALLOC = 3'd3,
        S_WAIT  = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CHART_AW-1:0]   r_addr;
    logic [3:0]            r_mask;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_overflow;
    logic [NUM_SLOTS-1:0]  r_valid;
    logic [1:0]            r_lane [NUM_SLOTS];
    logic [9:0]            r_y    [NUM_SLOTS];

    logic [1:0]            w_lane;
    logic [3:0]            w_lane_bit;
    logic [3:0]            w_mask_nxt;
    logic [NUM_SLOTS-1:0]  w_free;
    logic [NUM_SLOTS-1:0]  w_pick;
    logic                  w_any_free;
    logic                  w_alloc_en;
    logic                  w_last_addr;
    logic                  w_beat;
    logic [10:0]           w_sum [NUM_SLOTS];

    // Lowest lane index first: bit3 is lane 0.
    always_comb begin
        w_lane     = 2'd0;
        w_lane_bit = 4'b0000;
        casez (r_mask)
            4'b1???: begin w_lane = 2'd0; w_lane_bit = 4'b1000; end
            4'b01??: begin w_lane = 2'd1; w_lane_bit = 4'b0100; end
            4'b001?: begin w_lane = 2'd2; w_lane_bit = 4'b0010; end
            4'b0001: begin w_lane = 2'd3; w_lane_bit = 4'b0001; end
            default: begin w_lane = 2'd0; w_lane_bit = 4'b0000; end
        endcase
    end

    // Free slots are judged on the registered valid, so a slot retired this
    // cycle only becomes allocatable on the next one.
    assign w_mask_nxt  = r_mask & ~w_lane_bit;
    assign w_free      = ~r_valid;
    assign w_pick      = w_free & (~w_free + NUM_SLOTS'(1));
    assign w_any_free  = |w_free;
    assign w_alloc_en  = (r_state == S_ALLOC) && (|r_mask);
    assign w_last_addr = (r_addr == {CHART_AW{1'b1}});
    assign w_beat      = frame_tick && (r_cnt == c_BEAT_LAST);

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_sum[i] = {1'b0, r_y[i]} + c_SPEED;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FETCH;
            S_FETCH: w_state_nxt = S_LATCH;
            S_LATCH: w_state_nxt = S_ALLOC;
            S_ALLOC: begin
                if (w_mask_nxt == 4'b0000) begin
                    w_state_nxt = (c_LOOP || !w_last_addr) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT:  if (w_beat) w_state_nxt = S_FETCH;
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr     <= '0;
            r_mask     <= 4'b0000;
            r_cnt      <= '0;
            r_overflow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) r_addr <= '0;
                end
                S_LATCH: begin
                    r_mask <= chart_data;
                end
                S_ALLOC: begin
                    r_mask <= w_mask_nxt;
                    if ((|r_mask) && !w_any_free) r_overflow <= 1'b1;
                end
                S_WAIT: begin
                    // Address wraps naturally, which replays the chart when looping.
                    if (w_beat) begin
                        r_cnt  <= '0;
                        r_addr <= r_addr + CHART_AW'(1);
                    end else if (frame_tick) begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Allocation only ever targets an invalid slot and movement only touches
    // valid ones, so the two never collide on the same slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_lane[i] <= 2'd0;
                r_y[i]    <= 10'd0;
            end
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (w_alloc_en && w_pick[i]) begin
                    r_valid[i] <= 1'b1;
                    r_lane[i]  <= w_lane;
                    r_y[i]     <= 10'd0;
                end else if ((r_state != S_IDLE) && frame_tick && r_valid[i]) begin
                    if (w_sum[i] >= c_SCREEN_H) begin
                        r_valid[i] <= 1'b0;
                    end else begin
                        r_y[i] <= w_sum[i][9:0];
                    end
                end
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_pack
            assign slot_lane[2*g +: 2]  = r_lane[g];
            assign slot_y[10*g +: 10]   = r_y[g];
        end
    endgenerate

    assign slot_valid = r_valid;
    assign chart_addr = r_addr;
    assign overflow   = r_overflow;
    assign chart_done = !c_LOOP && (r_state == S_DONE) && (r_valid == '0);

endmodule
`default_nettype wire
